// File: rtl/wall_arbiter.sv
// -----------------------------------------------------------------------------
// wall_arbiter
//   Shares one wall-map lookup port between Pac-Man (requester 0) and three
//   ghosts (requesters 1-3). One query is served at a time by a four-state
//   FSM: IDLE -> ISSUE -> WAIT -> RESP. Out-of-range coordinates skip the
//   lookup and report a wall.
//
// Configuration macro:
//   WALL_ARB_PAC_PRIORITY_EN  defined   : req[0] always wins in IDLE, ghosts
//                                         round-robin among themselves.
//                             undefined : all four requesters round-robin.
//
// Parameters:
//   LOOKUP_LAT  cycles from o_wm_valid to i_wm_hit (1..4)
//   X_MAX/Y_MAX largest on-screen coordinates
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      synchronous active-low reset
//   i_req[3:0]   per-requester query request, held until its response
//   i_qx/i_qy    packed 10-bit coordinates, requester i at [10i+9:10i]
//   o_wm_valid   one-cycle lookup strobe to the wall map
//   o_wm_x/y     lookup coordinates
//   i_wm_hit     wall-map result, LOOKUP_LAT cycles after o_wm_valid
//   o_gnt        one-hot requester being served (issue through response)
//   o_rsp_valid  one-hot one-cycle response pulse
//   o_rsp_hit    wall result, valid with o_rsp_valid
//   o_busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module wall_arbiter #(
   parameter int LOOKUP_LAT = 1,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_req,
   input  logic [39:0] i_qx,
   input  logic [39:0] i_qy,
   output logic        o_wm_valid,
   output logic [9:0]  o_wm_x,
   output logic [9:0]  o_wm_y,
   input  logic        i_wm_hit,
   output logic [3:0]  o_gnt,
   output logic [3:0]  o_rsp_valid,
   output logic        o_rsp_hit,
   output logic        o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [9:0] LP_X_MAX = 10'(X_MAX);
   localparam logic [9:0] LP_Y_MAX = 10'(Y_MAX);
   localparam logic [1:0] LP_LAST  = 2'(LOOKUP_LAT - 1);

   state_t     r_state;
   logic [1:0] r_ptr;        // first index searched in the next IDLE
   logic [1:0] r_idx;        // index of the requester being served
   logic [1:0] r_cnt;        // cycles spent in WAIT
   logic       r_wm_valid;
   logic [9:0] r_wm_x;
   logic [9:0] r_wm_y;
   logic [3:0] r_gnt;
   logic [3:0] r_rsp_valid;
   logic       r_rsp_hit;
   logic       r_busy;

   logic [9:0] w_qx [4];
   logic [9:0] w_qy [4];
   logic       w_any;
   logic [1:0] w_win;
   logic [1:0] w_cand;
   logic [9:0] w_sel_x;
   logic [9:0] w_sel_y;
   logic       w_in_range;

   for (genvar g = 0; g < 4; g++) begin : g_unpack
      assign w_qx[g] = i_qx[10*g +: 10];
      assign w_qy[g] = i_qy[10*g +: 10];
   end

   // Winner search, starting at the round-robin pointer and wrapping 3->0.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      w_any  = 1'b0;
      w_win  = r_ptr;
      w_cand = r_ptr;
`ifdef WALL_ARB_PAC_PRIORITY_EN
      if (i_req[0]) begin
         w_any = 1'b1;
         w_win = 2'd0;
      end else begin
         // Ghosts only: index 0 is skipped so they rotate among themselves.
         for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_any && (w_cand != 2'd0) && i_req[w_cand]) begin
               w_any = 1'b1;
               w_win = w_cand;
            end
         end
      end
`else
      for (int k = 0; k < 4; k++) begin
         w_cand = r_ptr + 2'(k);
         if (!w_any && i_req[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
`endif
   end

   assign w_sel_x    = w_qx[w_win];
   assign w_sel_y    = w_qy[w_win];
   // Unsigned compare: "negative" coordinates arrive as large values and fail here.
   assign w_in_range = (w_sel_x <= LP_X_MAX) && (w_sel_y <= LP_Y_MAX);

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= 2'd0;
         r_idx       <= 2'd0;
         r_cnt       <= 2'd0;
         r_wm_valid  <= 1'b0;
         r_wm_x      <= 10'd0;
         r_wm_y      <= 10'd0;
         r_gnt       <= 4'd0;
         r_rsp_valid <= 4'd0;
         r_rsp_hit   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rsp_valid <= 4'd0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_idx      <= w_win;
                  r_gnt      <= 4'b0001 << w_win;
                  r_wm_x     <= w_sel_x;
                  r_wm_y     <= w_sel_y;
                  // The strobe is registered here so it is high during ISSUE.
                  r_wm_valid <= w_in_range;
                  r_busy     <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wm_valid <= 1'b0;
               if (r_wm_valid) begin
                  r_cnt   <= 2'd0;
                  r_state <= S_WAIT;
               end else begin
                  // Off-screen query: treat as wall without touching the map.
                  r_rsp_valid <= r_gnt;
                  r_rsp_hit   <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_WAIT: begin
               if (r_cnt == LP_LAST) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_hit   <= i_wm_hit;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_RESP: begin
               r_gnt     <= 4'd0;
               r_rsp_hit <= 1'b0;
               r_busy    <= 1'b0;
`ifdef WALL_ARB_PAC_PRIORITY_EN
               if (r_idx != 2'd0) r_ptr <= r_idx + 2'd1;
`else
               r_ptr <= r_idx + 2'd1;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_wm_valid  = r_wm_valid;
   assign o_wm_x      = r_wm_x;
   assign o_wm_y      = r_wm_y;
   assign o_gnt       = r_gnt;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_hit   = r_rsp_hit;
   assign o_busy      = r_busy;

endmodule
